// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers: control-bundle bit
// positions, default field widths and the main-slot source select.
package pipe_pkg;

    localparam int CTRL_REGW = 0;
    localparam int CTRL_MEMR = 1;
    localparam int CTRL_MEMW = 2;
    localparam int CTRL_BR   = 3;

    localparam int DEF_DATA_W     = 32;
    localparam int DEF_REG_ADDR_W = 5;
    localparam int DEF_CTRL_W     = 4;
    localparam int DEF_CNT_W      = 16;

    typedef enum logic {
        SRC_INPUT = 1'b0,
        SRC_SKID  = 1'b1
    } msrc_e;

    // Packed stage payload: adder, zero flag, ALU result, RD2, dest reg, ctrl.
    function automatic int payloadWidth(input int dataW, input int regW, input int ctrlW);
        return 3 * dataW + 1 + regW + ctrlW;
    endfunction

endpackage

// File: rtl/pipe_skid_slot.sv
// Generic valid + payload register. Load wins over clear; the payload keeps
// its last value while the slot is empty.
module pipe_skid_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic         valid,
    output logic [W-1:0] q
);

    // NOTE: the payload is reset along with valid so every field reads 0 during reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (load) begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            valid <= 1'b1;
            q     <= d;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/ex_mem_pipe_reg.sv
// EX/MEM pipeline stage register with valid/ready handshake, optional skid
// slot, synchronous flush and a saturating backpressure counter.
module ex_mem_pipe_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int REG_ADDR_W = DEF_REG_ADDR_W,
    parameter int CTRL_W     = DEF_CTRL_W,
    parameter int SKID       = 1,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_adder,
    input  logic                  in_zf,
    input  logic [DATA_W-1:0]     in_alu,
    input  logic [DATA_W-1:0]     in_rd2,
    input  logic [REG_ADDR_W-1:0] in_wreg,
    input  logic [CTRL_W-1:0]     in_ctrl,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_adder,
    output logic                  out_zf,
    output logic [DATA_W-1:0]     out_alu,
    output logic [DATA_W-1:0]     out_rd2,
    output logic [REG_ADDR_W-1:0] out_wreg,
    output logic [CTRL_W-1:0]     out_ctrl,
    output logic [CNT_W-1:0]      stall_cnt
);

    localparam int PW = payloadWidth(DATA_W, REG_ADDR_W, CTRL_W);

    logic [PW-1:0]     inBus;
    logic [PW-1:0]     mBus;
    logic [PW-1:0]     sBus;
    logic [PW-1:0]     mNext;
    logic              mValid;
    logic              sValid;
    logic              mLoad;
    logic              mClear;
    logic              sLoad;
    logic              sClear;
    msrc_e             mSrc;
    logic              accept;
    logic              drain;
    logic [CTRL_W-1:0] heldCtrl;
    logic [CNT_W-1:0]  stallCnt;

    assign inBus  = {in_adder, in_zf, in_alu, in_rd2, in_wreg, in_ctrl};
    assign accept = in_valid & in_ready;
    assign drain  = mValid & out_ready;
    assign mNext  = (mSrc == SRC_SKID) ? sBus : inBus;

    pipe_skid_slot #(.W(PW)) uMain (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (mLoad),
        .clear (mClear),
        .d     (mNext),
        .valid (mValid),
        .q     (mBus)
    );

    generate
        if (SKID != 0) begin : gSkid
            pipe_skid_slot #(.W(PW)) uSkid (
                .clk   (clk),
                .rst_n (rst_n),
                .load  (sLoad),
                .clear (sClear),
                .d     (inBus),
                .valid (sValid),
                .q     (sBus)
            );

            // Ready comes straight off a flop, so out_ready never reaches in_ready.
            assign in_ready = !sValid;

            // NOTE: every output gets a default first so no latch is inferred.
            always_comb begin
                mLoad  = 1'b0;
                mClear = 1'b0;
                mSrc   = SRC_INPUT;
                sLoad  = 1'b0;
                sClear = 1'b0;
                if (flush) begin
                    mClear = 1'b1;
                    sClear = 1'b1;
                end else if (!mValid || drain) begin
                    if (sValid) begin
                        mLoad = 1'b1;
                        mSrc  = SRC_SKID;
                        if (accept) sLoad  = 1'b1;
                        else        sClear = 1'b1;
                    end else if (accept) begin
                        mLoad = 1'b1;
                    end else begin
                        mClear = 1'b1;
                    end
                end else if (accept) begin
                    sLoad = 1'b1;
                end
            end
        end else begin : gDirect
            assign sValid   = 1'b0;
            assign sBus     = '0;
            assign sLoad    = 1'b0;
            assign sClear   = 1'b0;
            assign in_ready = !mValid | out_ready;

            always_comb begin
                mLoad  = 1'b0;
                mClear = 1'b0;
                mSrc   = SRC_INPUT;
                if (flush)       mClear = 1'b1;
                else if (accept) mLoad  = 1'b1;
                else if (drain)  mClear = 1'b1;
            end
        end
    endgenerate

    assign {out_adder, out_zf, out_alu, out_rd2, out_wreg, heldCtrl} = mBus;
    assign out_valid = mValid;
    // A bubble must look like a NOP to MEM; the data fields may keep stale values.
    assign out_ctrl  = mValid ? heldCtrl : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stallCnt <= '0;
        end else if (mValid && !out_ready && (stallCnt != {CNT_W{1'b1}})) begin
            stallCnt <= stallCnt + CNT_W'(1);
        end
    end

    assign stall_cnt = stallCnt;

    aSkidBehindMain: assert property (@(posedge clk) disable iff (!rst_n)
        sValid |-> mValid);

    aBubbleIsNop: assert property (@(posedge clk) disable iff (!rst_n)
        !out_valid |-> !(out_ctrl[CTRL_REGW] | out_ctrl[CTRL_MEMR] |
                         out_ctrl[CTRL_MEMW] | out_ctrl[CTRL_BR]));

    // A stalled entry stays put until MEM takes it or it is flushed.
    aHoldUnderStall: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready && !flush) |=> (out_valid && $stable(out_alu)));

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Bench for ex_mem_pipe_reg: a skid build with a 4-bit counter and a direct
// (no skid) build, table-driven vectors plus a handshake scoreboard.
module tb_ex_mem_pipe_reg;
    import pipe_pkg::*;

    localparam logic [3:0] C_ALU   = 4'(1 << CTRL_REGW);
    localparam logic [3:0] C_LOAD  = 4'((1 << CTRL_REGW) | (1 << CTRL_MEMR));
    localparam logic [3:0] C_STORE = 4'(1 << CTRL_MEMW);
    localparam logic [3:0] C_BR    = 4'(1 << CTRL_BR);

    logic clk;
    logic rst_n;

    logic        aFlush, aInValid, aInReady, aZf, aOutValid, aOutReady, aOutZf;
    logic [31:0] aAdder, aAlu, aRd2, aOutAdder, aOutAlu, aOutRd2;
    logic [4:0]  aWreg, aOutWreg;
    logic [3:0]  aCtrl, aOutCtrl, aStall;

    logic        bFlush, bInValid, bInReady, bZf, bOutValid, bOutReady, bOutZf;
    logic [31:0] bAdder, bAlu, bRd2, bOutAdder, bOutAlu, bOutRd2;
    logic [4:0]  bWreg, bOutWreg;
    logic [3:0]  bCtrl, bOutCtrl;
    logic [15:0] bStall;

    int checks = 0;
    int errors = 0;

    typedef logic [105:0] entry_t;
    entry_t qA[$];
    entry_t qB[$];

    typedef struct {
        logic        inValid;
        logic [31:0] alu;
        logic [3:0]  ctrl;
        logic        outReady;
        logic        expValid;
        logic [31:0] expAlu;
        logic [3:0]  expCtrl;
        logic        expInReady;
        logic [3:0]  expStall;
    } vec_t;

    vec_t vecs[12];

    ex_mem_pipe_reg #(.DATA_W(32), .REG_ADDR_W(5), .CTRL_W(4), .SKID(1), .CNT_W(4)) dutA (
        .clk(clk), .rst_n(rst_n), .flush(aFlush),
        .in_valid(aInValid), .in_ready(aInReady),
        .in_adder(aAdder), .in_zf(aZf), .in_alu(aAlu), .in_rd2(aRd2),
        .in_wreg(aWreg), .in_ctrl(aCtrl),
        .out_valid(aOutValid), .out_ready(aOutReady),
        .out_adder(aOutAdder), .out_zf(aOutZf), .out_alu(aOutAlu), .out_rd2(aOutRd2),
        .out_wreg(aOutWreg), .out_ctrl(aOutCtrl), .stall_cnt(aStall)
    );

    ex_mem_pipe_reg #(.DATA_W(32), .REG_ADDR_W(5), .CTRL_W(4), .SKID(0), .CNT_W(16)) dutB (
        .clk(clk), .rst_n(rst_n), .flush(bFlush),
        .in_valid(bInValid), .in_ready(bInReady),
        .in_adder(bAdder), .in_zf(bZf), .in_alu(bAlu), .in_rd2(bRd2),
        .in_wreg(bWreg), .in_ctrl(bCtrl),
        .out_valid(bOutValid), .out_ready(bOutReady),
        .out_adder(bOutAdder), .out_zf(bOutZf), .out_alu(bOutAlu), .out_rd2(bOutRd2),
        .out_wreg(bOutWreg), .out_ctrl(bOutCtrl), .stall_cnt(bStall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic driveA(input logic v, input logic [31:0] alu, input logic [3:0] ctrl,
                          input logic rdy);
        aInValid  = v;
        aAlu      = alu;
        aAdder    = alu + 32'h100;
        aZf       = alu[1];
        aRd2      = ~alu;
        aWreg     = alu[4:0] ^ 5'h15;
        aCtrl     = ctrl;
        aOutReady = rdy;
    endtask

    task automatic driveB(input logic v, input logic [31:0] alu, input logic [3:0] ctrl,
                          input logic rdy);
        bInValid  = v;
        bAlu      = alu;
        bAdder    = alu + 32'h200;
        bZf       = alu[0];
        bRd2      = alu ^ 32'hA5A5_0000;
        bWreg     = alu[4:0] ^ 5'h0A;
        bCtrl     = ctrl;
        bOutReady = rdy;
    endtask

    // Scoreboard: accepted entries are queued, drains pop and compare in order.
    always @(negedge clk) begin
        if (!rst_n) begin
            qA.delete();
            qB.delete();
        end else begin
            if (aOutValid && aOutReady) begin
                if (qA.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL a_drain: got entry alu=%0h expected no entry", aOutAlu);
                end else begin
                    check("a_drain", {aOutAdder, aOutZf, aOutAlu, aOutRd2, aOutWreg, aOutCtrl},
                          qA.pop_front());
                end
            end
            if (aFlush) qA.delete();
            else if (aInValid && aInReady) qA.push_back({aAdder, aZf, aAlu, aRd2, aWreg, aCtrl});

            if (bOutValid && bOutReady) begin
                if (qB.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL b_drain: got entry alu=%0h expected no entry", bOutAlu);
                end else begin
                    check("b_drain", {bOutAdder, bOutZf, bOutAlu, bOutRd2, bOutWreg, bOutCtrl},
                          qB.pop_front());
                end
            end
            if (bFlush) qB.delete();
            else if (bInValid && bInReady) qB.push_back({bAdder, bZf, bAlu, bRd2, bWreg, bCtrl});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //          inV   alu    ctrl     oR    expV  expAlu expCtrl  inR   stall
        vecs[0]  = '{1'b1, 32'h1,  C_ALU,   1'b1, 1'b1, 32'h1,  C_ALU,   1'b1, 4'd0};
        vecs[1]  = '{1'b1, 32'h2,  C_LOAD,  1'b1, 1'b1, 32'h2,  C_LOAD,  1'b1, 4'd0};
        vecs[2]  = '{1'b1, 32'h3,  C_STORE, 1'b1, 1'b1, 32'h3,  C_STORE, 1'b1, 4'd0};
        vecs[3]  = '{1'b0, 32'h0,  4'h0,    1'b1, 1'b0, 32'h3,  4'h0,    1'b1, 4'd0};
        vecs[4]  = '{1'b1, 32'h10, C_BR,    1'b0, 1'b1, 32'h10, C_BR,    1'b1, 4'd0};
        vecs[5]  = '{1'b1, 32'h20, C_LOAD,  1'b0, 1'b1, 32'h10, C_BR,    1'b0, 4'd1};
        vecs[6]  = '{1'b1, 32'h30, C_ALU,   1'b0, 1'b1, 32'h10, C_BR,    1'b0, 4'd2};
        vecs[7]  = '{1'b0, 32'h0,  4'h0,    1'b0, 1'b1, 32'h10, C_BR,    1'b0, 4'd3};
        vecs[8]  = '{1'b0, 32'h0,  4'h0,    1'b1, 1'b1, 32'h20, C_LOAD,  1'b1, 4'd3};
        vecs[9]  = '{1'b0, 32'h0,  4'h0,    1'b1, 1'b0, 32'h20, 4'h0,    1'b1, 4'd3};
        vecs[10] = '{1'b1, 32'h40, C_STORE, 1'b1, 1'b1, 32'h40, C_STORE, 1'b1, 4'd3};
        vecs[11] = '{1'b0, 32'h0,  4'h0,    1'b1, 1'b0, 32'h40, 4'h0,    1'b1, 4'd3};

        rst_n  = 1'b0;
        aFlush = 1'b0;
        bFlush = 1'b0;
        driveA(1'b0, 32'h0, 4'h0, 1'b1);
        driveB(1'b0, 32'h0, 4'h0, 1'b1);
        #3;
        check("rst_a_valid", aOutValid, 1'b0);
        check("rst_a_ready", aInReady, 1'b1);
        check("rst_a_stall", aStall, 4'd0);
        check("rst_a_alu", aOutAlu, 32'h0);
        check("rst_b_valid", bOutValid, 1'b0);
        check("rst_b_ready", bInReady, 1'b1);
        tick();
        tick();
        rst_n = 1'b1;

        // Streaming and backpressure on the skid build.
        for (int i = 0; i < 12; i++) begin
            driveA(vecs[i].inValid, vecs[i].alu, vecs[i].ctrl, vecs[i].outReady);
            tick();
            check($sformatf("vec%0d_valid", i), aOutValid, vecs[i].expValid);
            check($sformatf("vec%0d_alu", i), aOutAlu, vecs[i].expAlu);
            check($sformatf("vec%0d_ctrl", i), aOutCtrl, vecs[i].expCtrl);
            check($sformatf("vec%0d_ready", i), aInReady, vecs[i].expInReady);
            check($sformatf("vec%0d_stall", i), aStall, vecs[i].expStall);
        end
        check("a_nothing_lost", qA.size(), 0);

        // Flush with both slots full and a competing input.
        driveA(1'b1, 32'h50, C_ALU, 1'b0);
        tick();
        driveA(1'b1, 32'h60, C_LOAD, 1'b0);
        tick();
        check("a_skid_full_ready", aInReady, 1'b0);
        aFlush = 1'b1;
        driveA(1'b1, 32'h70, C_STORE, 1'b0);
        tick();
        aFlush = 1'b0;
        driveA(1'b0, 32'h0, 4'h0, 1'b1);
        check("a_flush_valid", aOutValid, 1'b0);
        check("a_flush_ctrl", aOutCtrl, 4'h0);
        check("a_flush_ready", aInReady, 1'b1);
        check("a_flush_stall", aStall, 4'd5);
        tick();
        tick();
        check("a_flush_no_c", aOutValid, 1'b0);
        check("a_flush_queue", qA.size(), 0);

        // Asynchronous reset between edges while stalled.
        driveA(1'b1, 32'h80, C_BR, 1'b0);
        tick();
        driveA(1'b0, 32'h0, 4'h0, 1'b0);
        tick();
        check("a_pre_rst_stall", aStall, 4'd6);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", aOutValid, 1'b0);
        check("arst_alu", aOutAlu, 32'h0);
        check("arst_adder", aOutAdder, 32'h0);
        check("arst_ctrl", aOutCtrl, 4'h0);
        check("arst_stall", aStall, 4'd0);
        check("arst_ready", aInReady, 1'b1);
        tick();
        rst_n = 1'b1;

        // Counter saturation at 15 with a 4-bit counter.
        driveA(1'b1, 32'h90, C_LOAD, 1'b0);
        tick();
        driveA(1'b0, 32'h0, 4'h0, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            tick();
            check($sformatf("sat_%0d", i), aStall, (i < 15) ? i : 15);
        end
        aOutReady = 1'b1;
        tick();
        check("sat_drained", aOutValid, 1'b0);
        check("sat_queue", qA.size(), 0);

        // Direct build: ready follows out_ready while the register is full.
        driveB(1'b1, 32'hA1, C_ALU, 1'b1);
        #1;
        check("b_ready_empty", bInReady, 1'b1);
        tick();
        check("b_out_a1", bOutAlu, 32'hA1);
        driveB(1'b1, 32'hA2, C_STORE, 1'b0);
        #1;
        check("b_ready_blocked", bInReady, 1'b0);
        tick();
        check("b_hold_a1", bOutAlu, 32'hA1);
        check("b_hold_valid", bOutValid, 1'b1);
        bOutReady = 1'b1;
        #1;
        check("b_ready_follow", bInReady, 1'b1);
        tick();
        check("b_out_a2", bOutAlu, 32'hA2);
        check("b_out_a2_ctrl", bOutCtrl, C_STORE);
        driveB(1'b0, 32'h0, 4'h0, 1'b1);
        tick();
        check("b_idle_valid", bOutValid, 1'b0);
        check("b_idle_ctrl", bOutCtrl, 4'h0);
        check("b_idle_ready", bInReady, 1'b1);
        check("b_stall", bStall, 16'd1);

        // Flush in the same cycle as a drain: the drain completes, the input is dropped.
        driveB(1'b1, 32'hB1, C_BR, 1'b1);
        tick();
        bFlush = 1'b1;
        driveB(1'b1, 32'hB2, C_LOAD, 1'b1);
        tick();
        bFlush = 1'b0;
        driveB(1'b0, 32'h0, 4'h0, 1'b1);
        check("b_flush_valid", bOutValid, 1'b0);
        check("b_flush_ready", bInReady, 1'b1);
        tick();
        check("b_flush_no_b2", bOutValid, 1'b0);
        check("b_queue", qB.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
